// File: rtl/decode24_hold.sv
// Registered 2-to-4 decoder: an accepted code drives its one-hot line for
// HOLD_CYCLES cycles, then pulses done; en low aborts a hold without done.
module decode24_hold #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  input  logic [1:0]       in_code,
  output logic             in_ready,
  output logic [3:0]       out_code,
  output logic             out_valid,
  output logic             done,
  output logic [CNT_W-1:0] acc_cnt
);

  localparam int unsigned HC_W = (HOLD_CYCLES <= 1) ? 1 : $clog2(HOLD_CYCLES);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [HC_W-1:0]  r_hold,  w_hold_nxt;
  logic [3:0]       r_code,  w_code_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_done,  w_done_nxt;
  logic [CNT_W-1:0] r_acc,   w_acc_nxt;
  logic             w_accept;

  assign in_ready = en && (r_state == IDLE);
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_hold  <= '0;
      r_code  <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
      r_code  <= w_code_nxt;
      r_valid <= w_valid_nxt;
      r_done  <= w_done_nxt;
      r_acc   <= w_acc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_code_nxt  = r_code;
    w_valid_nxt = r_valid;
    w_done_nxt  = 1'b0;
    w_acc_nxt   = r_acc;
    case (r_state)
      IDLE: begin
        w_code_nxt  = '0;
        w_valid_nxt = 1'b0;
        if (w_accept) begin
          w_state_nxt = HOLD;
          w_hold_nxt  = HC_W'(HOLD_CYCLES - 1);
          w_code_nxt  = 4'(4'b0001 << in_code);
          w_valid_nxt = 1'b1;
          if (r_acc != '1) begin
            w_acc_nxt = r_acc + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        // abort wins over normal completion, so done stays low when en drops
        if (!en) begin
          w_state_nxt = IDLE;
          w_hold_nxt  = '0;
          w_code_nxt  = '0;
          w_valid_nxt = 1'b0;
        end else if (r_hold != '0) begin
          w_hold_nxt = r_hold - HC_W'(1);
        end else begin
          w_state_nxt = IDLE;
          w_code_nxt  = '0;
          w_valid_nxt = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_hold_nxt  = '0;
        w_code_nxt  = '0;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  assign out_code  = r_code;
  assign out_valid = r_valid;
  assign done      = r_done;
  assign acc_cnt   = r_acc;

endmodule

// File: tb/tb_decode24_hold.sv
// Vector-table bench for decode24_hold: HOLD_CYCLES=4/CNT_W=8 instance for the
// main behaviour, HOLD_CYCLES=1/CNT_W=2 instance for minimum hold and saturation.
module tb_decode24_hold;

  localparam int unsigned HOLD_A = 4;

  logic clk;
  logic rst_n;

  logic       a_en, a_v;
  logic [1:0] a_code;
  logic       a_rdy, a_ov, a_dn;
  logic [3:0] a_oc;
  logic [7:0] a_acc;

  logic       b_en, b_v;
  logic [1:0] b_code;
  logic       b_rdy, b_ov, b_dn;
  logic [3:0] b_oc;
  logic [1:0] b_acc;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         sel;
    logic       en;
    logic       v;
    logic [1:0] code;
    logic       rdy;
    logic [3:0] oc;
    logic       ov;
    logic       dn;
    logic [7:0] acc;
  } vec_t;

  vec_t tab[$];
  vec_t sb_q[$];
  int   cur_sel;

  decode24_hold #(.HOLD_CYCLES(HOLD_A), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .en(a_en), .in_valid(a_v), .in_code(a_code),
    .in_ready(a_rdy), .out_code(a_oc), .out_valid(a_ov), .done(a_dn), .acc_cnt(a_acc)
  );

  decode24_hold #(.HOLD_CYCLES(1), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .en(b_en), .in_valid(b_v), .in_code(b_code),
    .in_ready(b_rdy), .out_code(b_oc), .out_valid(b_ov), .done(b_dn), .acc_cnt(b_acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0h want=%0h", nm, idx, act, exp);
    end
  endtask

  function automatic void add(input logic en, input logic v, input int code,
                              input logic rdy, input logic [3:0] oc, input logic ov,
                              input logic dn, input int acc);
    vec_t r;
    r.sel  = cur_sel;
    r.en   = en;
    r.v    = v;
    r.code = 2'(code);
    r.rdy  = rdy;
    r.oc   = oc;
    r.ov   = ov;
    r.dn   = dn;
    r.acc  = 8'(acc);
    tab.push_back(r);
  endfunction

  function automatic logic [3:0] onehot(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return 4'(one << c);
  endfunction

  // accept code c, hold for hold_len edges (inputs hv/hc meanwhile), then done
  function automatic void add_burst(input int c, input int acc, input int hold_len,
                                    input logic hv, input int hc);
    add(1'b1, 1'b1, c, 1'b1, onehot(c), 1'b1, 1'b0, acc);
    for (int i = 1; i < hold_len; i++)
      add(1'b1, hv, hc, 1'b0, onehot(c), 1'b1, 1'b0, acc);
    add(1'b1, hv, hc, 1'b0, 4'b0000, 1'b0, 1'b1, acc);
  endfunction

  task automatic step(input vec_t v, input int idx);
    vec_t e;
    @(negedge clk);
    if (v.sel == 0) begin
      a_en = v.en; a_v = v.v; a_code = v.code;
    end else begin
      b_en = v.en; b_v = v.v; b_code = v.code;
    end
    #1;
    check("in_ready", idx, (v.sel == 0) ? a_rdy : b_rdy, v.rdy);
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    if (e.sel == 0) begin
      check("out_code", idx, a_oc, e.oc);
      check("out_valid", idx, a_ov, e.ov);
      check("done", idx, a_dn, e.dn);
      check("acc_cnt", idx, a_acc, e.acc);
    end else begin
      check("b_out_code", idx, b_oc, e.oc);
      check("b_out_valid", idx, b_ov, e.ov);
      check("b_done", idx, b_dn, e.dn);
      check("b_acc_cnt", idx, {6'b0, b_acc}, e.acc);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_en = 1'b1; a_v = 1'b0; a_code = 2'd0;
    b_en = 1'b1; b_v = 1'b0; b_code = 2'd0;

    cur_sel = 0;
    // single code 2
    add_burst(2, 1, HOLD_A, 1'b0, 0);
    add(1'b1, 1'b0, 0, 1'b1, 4'b0000, 1'b0, 1'b0, 1);
    // back-to-back sweep with in_valid held high
    for (int c = 0; c < 4; c++) add_burst(c, 2 + c, HOLD_A, 1'b1, c);
    add(1'b1, 1'b0, 0, 1'b1, 4'b0000, 1'b0, 1'b0, 5);
    // new code presented during hold is deferred to the done cycle
    add_burst(1, 6, HOLD_A, 1'b1, 3);
    add_burst(3, 7, HOLD_A, 1'b0, 0);
    add(1'b1, 1'b0, 0, 1'b1, 4'b0000, 1'b0, 1'b0, 7);
    // abort after two hold cycles
    add(1'b1, 1'b1, 3, 1'b1, 4'b1000, 1'b1, 1'b0, 8);
    add(1'b1, 1'b0, 0, 1'b0, 4'b1000, 1'b1, 1'b0, 8);
    add(1'b1, 1'b0, 0, 1'b0, 4'b1000, 1'b1, 1'b0, 8);
    add(1'b0, 1'b0, 0, 1'b0, 4'b0000, 1'b0, 1'b0, 8);
    add(1'b0, 1'b1, 0, 1'b0, 4'b0000, 1'b0, 1'b0, 8);
    add(1'b0, 1'b1, 2, 1'b0, 4'b0000, 1'b0, 1'b0, 8);
    add(1'b1, 1'b0, 0, 1'b1, 4'b0000, 1'b0, 1'b0, 8);
    // abort on the same cycle the hold counter reaches zero
    add(1'b1, 1'b1, 0, 1'b1, 4'b0001, 1'b1, 1'b0, 9);
    for (int i = 0; i < 3; i++) add(1'b1, 1'b0, 0, 1'b0, 4'b0001, 1'b1, 1'b0, 9);
    add(1'b0, 1'b0, 0, 1'b0, 4'b0000, 1'b0, 1'b0, 9);
    add(1'b1, 1'b0, 0, 1'b1, 4'b0000, 1'b0, 1'b0, 9);

    cur_sel = 1;
    // HOLD_CYCLES=1 bursts, acc_cnt saturates at 3
    for (int n = 0; n < 5; n++) add_burst(n % 4, (n < 3) ? n + 1 : 3, 1, 1'b1, n % 4);
    add(1'b1, 1'b0, 0, 1'b1, 4'b0000, 1'b0, 1'b0, 3);

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_code", 0, a_oc, 4'b0000);
    check("rst_out_valid", 0, a_ov, 1'b0);
    check("rst_done", 0, a_dn, 1'b0);
    check("rst_acc_cnt", 0, a_acc, 8'd0);
    check("rst_in_ready", 0, a_rdy, 1'b1);
    check("rst_b_acc_cnt", 0, b_acc, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tab.size(); i++) step(tab[i], i);

    // asynchronous reset in the middle of a hold
    begin
      vec_t r;
      r = '{0, 1'b1, 1'b1, 2'd2, 1'b1, 4'b0100, 1'b1, 1'b0, 8'd10};
      step(r, 100);
      r = '{0, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0100, 1'b1, 1'b0, 8'd10};
      step(r, 101);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_out_code", 0, a_oc, 4'b0000);
      check("async_out_valid", 0, a_ov, 1'b0);
      check("async_done", 0, a_dn, 1'b0);
      check("async_acc_cnt", 0, a_acc, 8'd0);
      check("async_in_ready", 0, a_rdy, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      tab.delete();
      cur_sel = 0;
      add_burst(1, 1, HOLD_A, 1'b0, 0);
      add(1'b1, 1'b0, 0, 1'b1, 4'b0000, 1'b0, 1'b0, 1);
      for (int i = 0; i < tab.size(); i++) step(tab[i], 200 + i);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
